// File: rtl/dm_tb_boot_rom.sv
// Bench-side boot ROM slave: OBI-style req/gnt/rvalid port serving a
// lui+jalr stub that jumps to BOOT_ADDR; every other word is a self-loop.
module dm_tb_boot_rom #(
    parameter logic [31:0] ROM_BASE  = 32'h1A00_0000,
    parameter logic [31:0] ROM_LEN   = 32'h0010_0000,
    parameter logic [31:0] BOOT_ADDR = 32'h1C00_0080,
    parameter int unsigned RESP_LAT  = 1,
    parameter int unsigned GNT_STALL = 0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    if (RESP_LAT == 0 || RESP_LAT > 4) begin : g_bad_lat
        $error("dm_tb_boot_rom: RESP_LAT must be 1..4");
    end
    if (GNT_STALL > 7) begin : g_bad_stall
        $error("dm_tb_boot_rom: GNT_STALL must be 0..7");
    end
    if (ROM_LEN == 0 || (ROM_LEN & (ROM_LEN - 32'd1)) != 0) begin : g_bad_len
        $error("dm_tb_boot_rom: ROM_LEN must be a power of two");
    end

    // hi absorbs the sign extension jalr applies to the low 12 bits
    localparam logic [19:0] BOOT_HI = BOOT_ADDR[31:12] + {19'd0, BOOT_ADDR[11]};
    localparam logic [11:0] BOOT_LO = BOOT_ADDR[11:0];
    localparam logic [31:0] WORD_LUI  = {BOOT_HI, 5'd5, 7'b0110111};
    localparam logic [31:0] WORD_JALR = {BOOT_LO, 5'd5, 3'b000, 5'd0, 7'h67};
    localparam logic [31:0] WORD_LOOP = 32'h0000_006F;

    logic [2:0] stall_q;
    logic       xfer;

    assign gnt_o = rst_ni & req_i & (stall_q == 3'(GNT_STALL));
    assign xfer  = req_i & gnt_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q <= '0;
        end else if (req_i && !gnt_o) begin
            stall_q <= stall_q + 3'd1;
        end else begin
            stall_q <= '0;
        end
    end

    logic [32:0] addr_ext;
    logic [32:0] lo_bound;
    logic [32:0] hi_bound;
    logic        in_range;
    logic [31:0] offs;
    logic [29:0] idx;
    logic        resp_err;
    logic [31:0] resp_data;

    // 33-bit compare so a region ending at 2^32 does not wrap
    assign addr_ext = {1'b0, addr_i};
    assign lo_bound = {1'b0, ROM_BASE};
    assign hi_bound = {1'b0, ROM_BASE} + {1'b0, ROM_LEN};
    assign in_range = (addr_ext >= lo_bound) && (addr_ext < hi_bound);
    assign offs     = addr_i - ROM_BASE;
    assign idx      = offs[31:2];

    always_comb begin
        resp_err  = 1'b0;
        resp_data = '0;
        if (!in_range) begin
            resp_err = 1'b1;
        end else if (addr_i[1:0] != 2'b00) begin
            resp_err = 1'b1;
        end else if (we_i) begin
            resp_err = 1'b1;
        end else if (idx == 30'd0) begin
            resp_data = WORD_LUI;
        end else if (idx == 30'd1) begin
            resp_data = WORD_JALR;
        end else begin
            resp_data = WORD_LOOP;
        end
    end

    logic [RESP_LAT-1:0] vld_q;
    logic [RESP_LAT-1:0] err_q;
    logic [31:0]         data_q [RESP_LAT];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
            err_q <= '0;
            for (int i = 0; i < RESP_LAT; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            vld_q[0]  <= xfer;
            err_q[0]  <= xfer & resp_err;
            data_q[0] <= xfer ? resp_data : 32'd0;
            for (int i = 1; i < RESP_LAT; i++) begin
                vld_q[i]  <= vld_q[i-1];
                err_q[i]  <= err_q[i-1];
                data_q[i] <= data_q[i-1];
            end
        end
    end

    assign rvalid_o = vld_q[RESP_LAT-1];
    assign err_o    = vld_q[RESP_LAT-1] & err_q[RESP_LAT-1];
    assign rdata_o  = vld_q[RESP_LAT-1] ? data_q[RESP_LAT-1] : 32'd0;

    logic unused_ok;
    assign unused_ok = ^{be_i, wdata_i, offs[1:0]};

endmodule

// File: tb/tb_dm_tb_boot_rom.sv
// Bench for dm_tb_boot_rom: four differently parameterised instances checked
// every cycle against a transaction-level model, plus literal expectations.
module tb_dm_tb_boot_rom;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n [4];
    logic        req   [4];
    logic        we    [4];
    logic [31:0] addr  [4];
    logic [3:0]  be    [4];
    logic [31:0] wdata [4];
    logic        gnt   [4];
    logic        rvalid[4];
    logic [31:0] rdata [4];
    logic        err   [4];

    for (genvar k = 0; k < 4; k++) begin : g_dut
        localparam int unsigned LAT   = (k == 2) ? 4 : (k == 3) ? 3 : 1;
        localparam int unsigned STALL = (k == 2) ? 3 : 0;
        localparam logic [31:0] BOOT  = (k == 1) ? 32'h1C00_0880 : 32'h1C00_0080;
        dm_tb_boot_rom #(
            .ROM_BASE (32'h1A00_0000),
            .ROM_LEN  (32'h0010_0000),
            .BOOT_ADDR(BOOT),
            .RESP_LAT (LAT),
            .GNT_STALL(STALL)
        ) u_dut (
            .clk_i   (clk),
            .rst_ni  (rst_n[k]),
            .req_i   (req[k]),
            .we_i    (we[k]),
            .addr_i  (addr[k]),
            .be_i    (be[k]),
            .wdata_i (wdata[k]),
            .gnt_o   (gnt[k]),
            .rvalid_o(rvalid[k]),
            .rdata_o (rdata[k]),
            .err_o   (err[k])
        );
    end

    function automatic int f_lat(input int k);
        return (k == 2) ? 4 : (k == 3) ? 3 : 1;
    endfunction
    function automatic int f_stall(input int k);
        return (k == 2) ? 3 : 0;
    endfunction
    function automatic logic [31:0] f_boot(input int k);
        return (k == 1) ? 32'h1C00_0880 : 32'h1C00_0080;
    endfunction

    // {err, data} straight from the address map rules
    function automatic logic [32:0] model(input logic [31:0] boot,
                                          input logic w, input logic [31:0] a);
        longint      ua;
        longint      base;
        longint      len;
        int unsigned idx;
        int unsigned hi;
        int unsigned word;
        ua   = longint'(a);
        base = 64'h1A00_0000;
        len  = 64'h0010_0000;
        if (ua < base || ua >= base + len) return {1'b1, 32'd0};
        if (a % 4 != 0) return {1'b1, 32'd0};
        if (w) return {1'b1, 32'd0};
        idx = (a - 32'h1A00_0000) / 4;
        hi  = ((boot / 4096) + ((boot / 2048) % 2)) % (1 << 20);
        if (idx == 0) begin
            word = hi * 4096 + 5 * 128 + 'h37;
            return {1'b0, word};
        end
        if (idx == 1) begin
            word = (boot % 4096) * (1 << 20) + 5 * (1 << 15) + 'h67;
            return {1'b0, word};
        end
        return {1'b0, 32'h0000_006F};
    endfunction

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t   q        [4][$];
    int     held     [4];
    longint log_data [4][$];
    longint log_err  [4][$];
    longint log_cyc  [4][$];
    longint g_cyc    [4][$];
    int     cyc = 0;
    int     tests = 0;
    int     fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int k,
                         input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s inst%0d cyc%0d: got %h want %h", name, k, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (!rst_n[k]) begin
                q[k].delete();
                held[k] = 0;
                check("reset_outs", k, {gnt[k], rvalid[k], err[k], rdata[k]}, 64'd0);
            end else begin
                logic       exp_g;
                logic [32:0] r;
                exp_g = req[k] && (held[k] == f_stall(k));
                check("gnt", k, {63'd0, gnt[k]}, {63'd0, exp_g});
                if (req[k] && gnt[k]) g_cyc[k].push_back(cyc);
                if (rvalid[k]) begin
                    log_data[k].push_back(rdata[k]);
                    log_err[k].push_back(err[k]);
                    log_cyc[k].push_back(cyc);
                end
                if (q[k].size() > 0 && q[k][0].due == cyc) begin
                    check("resp", k, {rvalid[k], err[k], rdata[k]},
                          {1'b1, q[k][0].err, q[k][0].data});
                    void'(q[k].pop_front());
                end else begin
                    check("idle", k, {rvalid[k], err[k], rdata[k]}, 64'd0);
                end
                if (req[k] && exp_g) begin
                    r = model(f_boot(k), we[k], addr[k]);
                    q[k].push_back('{cyc + f_lat(k), r[32], r[31:0]});
                end
                held[k] = (req[k] && !exp_g) ? held[k] + 1 : 0;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic xfer(input int k, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input int hold);
        req[k]   = 1'b1;
        we[k]    = w;
        addr[k]  = a;
        be[k]    = 4'hF;
        wdata[k] = d;
        idle(hold);
        req[k]   = 1'b0;
        we[k]    = 1'b0;
        addr[k]  = '0;
        be[k]    = '0;
        wdata[k] = '0;
    endtask

    function automatic longint at(input int which, input int k, input int i);
        case (which)
            0: return (i < log_data[k].size()) ? log_data[k][i] : -1;
            1: return (i < log_err[k].size()) ? log_err[k][i] : -1;
            2: return (i < log_cyc[k].size()) ? log_cyc[k][i] : -1000;
            default: return (i < g_cyc[k].size()) ? g_cyc[k][i] : -1000;
        endcase
    endfunction

    longint exp0_d [8] = '{32'h1C00_02B7, 32'h0802_8067, 32'h0000_006F, 0, 0, 0,
                           32'h1C00_02B7, 0};
    longint exp0_e [8] = '{0, 0, 0, 1, 1, 1, 0, 1};
    longint exp2_d [4] = '{32'h1C00_02B7, 32'h0802_8067, 32'h0000_006F, 32'h0000_006F};
    int r0;
    int r2;

    initial begin
        for (int k = 0; k < 4; k++) begin
            rst_n[k] = 1'b0;
            req[k]   = 1'b0;
            we[k]    = 1'b0;
            addr[k]  = '0;
            be[k]    = '0;
            wdata[k] = '0;
            held[k]  = 0;
        end
        idle(3);
        for (int k = 0; k < 4; k++) rst_n[k] = 1'b1;
        idle(2);

        xfer(0, 1'b0, 32'h1A00_0000, 0, 1);
        xfer(0, 1'b0, 32'h1A00_0004, 0, 1);
        xfer(0, 1'b0, 32'h1A00_0100, 0, 1);
        xfer(0, 1'b0, 32'h1A10_0000, 0, 1);
        xfer(0, 1'b0, 32'h19FF_FFFC, 0, 1);
        xfer(0, 1'b1, 32'h1A00_0000, 32'hDEAD_BEEF, 1);
        xfer(0, 1'b0, 32'h1A00_0000, 0, 1);
        xfer(0, 1'b0, 32'h1A00_0002, 0, 1);
        idle(3);

        xfer(1, 1'b0, 32'h1A00_0000, 0, 1);
        xfer(1, 1'b0, 32'h1A00_0004, 0, 1);
        idle(3);

        r0 = cyc;
        xfer(2, 1'b0, 32'h1A00_0000, 0, 4);
        xfer(2, 1'b0, 32'h1A00_0004, 0, 4);
        xfer(2, 1'b0, 32'h1A00_0008, 0, 4);
        idle(6);
        r2 = cyc;
        xfer(2, 1'b0, 32'h1A00_000C, 0, 2);
        idle(1);
        xfer(2, 1'b0, 32'h1A00_000C, 0, 4);
        idle(6);

        xfer(3, 1'b0, 32'h1A00_0000, 0, 1);
        xfer(3, 1'b0, 32'h1A00_0004, 0, 1);
        xfer(3, 1'b0, 32'h1A00_0008, 0, 1);
        rst_n[3] = 1'b0;
        idle(1);
        rst_n[3] = 1'b1;
        idle(2);
        xfer(3, 1'b0, 32'h1A00_0004, 0, 1);
        idle(8);

        check("inst0_count", 0, log_data[0].size(), 8);
        for (int i = 0; i < 8; i++) begin
            check("inst0_data", 0, at(0, 0, i), exp0_d[i]);
            check("inst0_err", 0, at(1, 0, i), exp0_e[i]);
        end
        check("inst0_lat", 0, at(2, 0, 0) - at(3, 0, 0), 1);
        check("inst0_b2b", 0, at(3, 0, 1) - at(3, 0, 0), 1);
        check("inst1_lui", 1, at(0, 1, 0), 32'h1C00_12B7);
        check("inst1_jalr", 1, at(0, 1, 1), 32'h8802_8067);
        check("inst2_gnts", 2, g_cyc[2].size(), 4);
        check("inst2_stall0", 2, at(3, 2, 0) - r0, 3);
        check("inst2_stall1", 2, at(3, 2, 1) - at(3, 2, 0), 4);
        check("inst2_stall2", 2, at(3, 2, 2) - at(3, 2, 1), 4);
        for (int i = 0; i < 3; i++) begin
            check("inst2_lat", 2, at(2, 2, i) - at(3, 2, i), 4);
        end
        for (int i = 0; i < 4; i++) begin
            check("inst2_data", 2, at(0, 2, i), exp2_d[i]);
        end
        check("inst2_restall", 2, at(3, 2, 3) - r2, 6);
        check("inst3_gnts", 3, g_cyc[3].size(), 4);
        check("inst3_count", 3, log_data[3].size(), 1);
        check("inst3_data", 3, at(0, 3, 0), 32'h0802_8067);
        check("inst3_lat", 3, at(2, 3, 0) - at(3, 3, 3), 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dm_tb_boot_rom.md
Name: dm_tb_boot_rom

Overview:
- Testbench-side instruction memory slave for the debug-module bench, mapped at the ROM region of the PULPissimo-like map: base 0x1A00_0000, length 0x0010_0000.
- Sits between the core instruction/data bus and the bench memory map.
- Serves a generated two-instruction boot stub (lui + jalr) that jumps to a configurable boot address in SRAM; all other words hold a self-loop.
- Implements an OBI-style req/gnt/rvalid handshake with configurable grant stall and response latency.
- Returns errors for writes, misaligned accesses and out-of-range addresses.

Parameters:
- ROM_BASE, 32'h1A00_0000, region base address.
- ROM_LEN, 32'h0010_0000, region length in bytes; must be a power of two.
- BOOT_ADDR, 32'h1C00_0080, jump target of the stub.
- RESP_LAT, 1, cycles from grant to rvalid; legal range 1..4.
- GNT_STALL, 0, cycles req_i must be held high before gnt_o asserts; legal range 0..7.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- req_i  in  1  request valid.
- we_i  in  1  write enable.
- addr_i  in  32  byte address.
- be_i  in  4  byte enables; ignored for reads.
- wdata_i  in  32  write data; ignored.
- gnt_o  out  1  request accepted this cycle.
- rvalid_o  out  1  response valid.
- rdata_o  out  32  read data.
- err_o  out  1  error response; qualified by rvalid_o.

Behaviour:
- Reset: gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0. Response pipeline and stall counter are cleared.
- Grant, GNT_STALL=0: gnt_o = req_i combinationally, so one request is accepted per cycle.
- Grant, GNT_STALL=N>0:
  - stall counter increments each cycle req_i=1 and gnt_o=0;
  - gnt_o=1 combinationally when counter==N and req_i=1;
  - counter clears on grant, or when req_i drops before grant;
  - back-to-back requests each pay N stall cycles.
- Transfer: a request transfers on the rising edge where req_i & gnt_o.
- Response pipeline: RESP_LAT-deep shift register of {valid, err, data}.
  - A transfer loads stage 0 with valid=1; cycles without a transfer load valid=0.
  - Outputs are driven from the last stage, so rvalid_o rises exactly RESP_LAT cycles after the grant edge.
  - Responses have no backpressure and stay in request order. Up to RESP_LAT requests may be outstanding.
- Response classification, first match wins:
  1. addr_i outside [ROM_BASE, ROM_BASE+ROM_LEN) → err=1, data=0.
  2. addr_i[1:0]!=0 → err=1, data=0.
  3. we_i=1 → err=1, data=0; contents are unchanged.
  4. Otherwise err=0, data = word selected by idx = (addr_i-ROM_BASE)>>2.
- Range compare: done in 33-bit arithmetic so ROM_BASE+ROM_LEN does not wrap.
- Word contents, with hi = BOOT_ADDR[31:12] + BOOT_ADDR[11] (mod 2^20, compensating jalr sign extension) and lo = BOOT_ADDR[11:0]:
  - idx 0: lui rd=x5, imm=hi → {hi, 5'd5, 7'b0110111}.
  - idx 1: jalr rd=x0, rs1=x5, offset=lo → {lo, 5'd5, 3'b0, 5'd0, 7'h67}.
  - idx ≥2: jal x0, 0 → 32'h0000_006F.
- Idle outputs: when rvalid_o=0, rdata_o and err_o are 0.
- Reset mid-operation: all in-flight responses are discarded and no rvalid_o occurs for them; the stall counter is cleared.
- Parameter checks: out-of-range RESP_LAT or GNT_STALL, or a non-power-of-two ROM_LEN, triggers an elaboration-time $error.

Test Plan:
- Defaults; read 0x1A00_0000, then 0x1A00_0004 back-to-back → gnt both cycles; rvalid 1 cycle after each grant; rdata 0x1C00_02B7 then 0x0802_8067; err=0.
- BOOT_ADDR=0x1C00_0880; read idx 0 and 1 → 0x1C00_12B7 (hi carries) and 0x8802_8067.
- Read 0x1A00_0100 → 0x0000_006F. Read 0x1A10_0000 (first byte past the region) → err=1, rdata=0. Read 0x19FF_FFFC → err=1.
- Write 0x1A00_0000 with be=4'hF, wdata=0xDEADBEEF → err=1; a subsequent read returns 0x1C00_02B7. Read 0x1A00_0002 → err=1.
- GNT_STALL=3, RESP_LAT=4; three consecutive reads with req held:
  - each gnt arrives after 3 stall cycles;
  - rvalid occurs 4 cycles after each grant, in order.
  - Separately, drop req after 2 stall cycles, then re-raise → full 3-cycle stall again.
- RESP_LAT=3; issue three granted reads; assert rst_ni=0 for one cycle before the first rvalid → no rvalid afterwards; all outputs 0 during reset; a new read after reset completes normally.
